// File: rtl/intr_pulse_gen_pkg.sv
// Shared types and defaults for the interrupt set/clear pulse generator.
// The default tick period is derived from the clock and tick rates.
package intr_pulse_gen_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    localparam int unsigned CLK_HZ_DEFAULT  = 100_000_000;
    localparam int unsigned TICK_HZ_DEFAULT = 10;

    function automatic int unsigned calc_period(input int unsigned clk_hz,
                                                input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/intr_pulse_gen_period_ticker.sv
// Free-running period counter: counts 0..PERIOD-1 while enabled, held at 0 otherwise.
// tick is combinational and high in the last cycle of each period.
module intr_pulse_gen_period_ticker #(
    parameter int unsigned PERIOD = 10_000_000,
    parameter int unsigned CNT_W  = 24
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    logic [CNT_W-1:0] r_count;
    logic             w_last;

    assign w_last = (r_count == CNT_W'(PERIOD - 1));
    assign tick   = enable && w_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (!enable || w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/intr_pulse_gen.sv
// Turns periodic ticks and processor acks into one-cycle set/clear pulses for an
// external S/R request flag, and counts ticks that land on an unacknowledged request.
module intr_pulse_gen
    import intr_pulse_gen_pkg::*;
#(
    parameter int unsigned PERIOD = calc_period(CLK_HZ_DEFAULT, TICK_HZ_DEFAULT),
    parameter int unsigned CNT_W  = 24,
    parameter int unsigned OVR_W  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             ack,
    input  logic             clr_ovr,
    output logic             set_pulse,
    output logic             clr_pulse,
    output logic             pending,
    output logic             overrun,
    output logic [OVR_W-1:0] overrun_cnt
);

    state_t           r_state;
    logic             r_set_pulse;
    logic             r_clr_pulse;
    logic             r_overrun;
    logic [OVR_W-1:0] r_overrun_cnt;
    logic             w_tick;
    logic             w_ovr_evt;

    intr_pulse_gen_period_ticker #(
        .PERIOD (PERIOD),
        .CNT_W  (CNT_W)
    ) u_ticker (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .tick    (w_tick)
    );

    // A tick coinciding with ack replaces the request instead of overrunning it.
    assign w_ovr_evt = (r_state == PENDING) && w_tick && !ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_set_pulse <= 1'b0;
            r_clr_pulse <= 1'b0;
        end else begin
            r_set_pulse <= 1'b0;
            r_clr_pulse <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_tick) begin
                        r_set_pulse <= 1'b1;
                        r_state     <= PENDING;
                    end
                end
                PENDING: begin
                    if (w_tick && ack) begin
                        r_set_pulse <= 1'b1;
                    end else if (ack) begin
                        r_clr_pulse <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overrun     <= 1'b0;
            r_overrun_cnt <= '0;
        end else if (clr_ovr) begin
            r_overrun     <= w_ovr_evt;
            r_overrun_cnt <= w_ovr_evt ? OVR_W'(1) : '0;
        end else if (w_ovr_evt) begin
            r_overrun <= 1'b1;
            if (r_overrun_cnt != '1) begin
                r_overrun_cnt <= r_overrun_cnt + OVR_W'(1);
            end
        end
    end

    assign set_pulse   = r_set_pulse;
    assign clr_pulse   = r_clr_pulse;
    assign pending     = (r_state == PENDING);
    assign overrun     = r_overrun;
    assign overrun_cnt = r_overrun_cnt;

endmodule

// File: tb/tb_intr_pulse_gen.sv
// Directed bench for intr_pulse_gen with PERIOD=4, OVR_W=2; outputs sampled 1ns after posedge.
module tb_intr_pulse_gen;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       ack;
    logic       clr_ovr;
    logic       set_pulse;
    logic       clr_pulse;
    logic       pending;
    logic       overrun;
    logic [1:0] overrun_cnt;

    int total = 0;
    int bad   = 0;

    intr_pulse_gen #(
        .PERIOD (4),
        .CNT_W  (3),
        .OVR_W  (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .ack         (ack),
        .clr_ovr     (clr_ovr),
        .set_pulse   (set_pulse),
        .clr_pulse   (clr_pulse),
        .pending     (pending),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares {set, clr, pending, overrun, overrun_cnt} against expectations.
    task automatic chk(input string tag, input logic s, input logic c, input logic p,
                       input logic o, input logic [1:0] n);
        logic [5:0] obs;
        logic [5:0] exp;
        obs = {set_pulse, clr_pulse, pending, overrun, overrun_cnt};
        exp = {s, c, p, o, n};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed set/clr/pend/ovr/cnt=%b required=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b required=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1ns after a posedge with everything idle and reset released.
    task automatic do_reset();
        enable  = 1'b0;
        ack     = 1'b0;
        clr_ovr = 1'b0;
        #2;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        cyc(1);
    endtask

    initial begin
        logic seen;
        reset_n = 1'b1;
        enable  = 1'b0;
        ack     = 1'b0;
        clr_ovr = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset_state", 0, 0, 0, 0, 2'd0);
        reset_n = 1'b1;
        cyc(1);

        // 1: first tick latency, then overruns up to saturation
        enable = 1'b1;
        cyc(3);
        chk("t1_no_set_before_tick", 0, 0, 0, 0, 2'd0);
        cyc(1);
        chk("t1_first_set", 1, 0, 1, 0, 2'd0);
        cyc(1);
        chk("t1_set_one_cycle", 0, 0, 1, 0, 2'd0);
        cyc(3);
        chk("t1_ovr1", 0, 0, 1, 1, 2'd1);
        cyc(4);
        chk("t1_ovr2", 0, 0, 1, 1, 2'd2);
        cyc(4);
        chk("t1_ovr3", 0, 0, 1, 1, 2'd3);
        cyc(4);
        chk("t1_ovr_saturate", 0, 0, 1, 1, 2'd3);

        // 2: ack two cycles after the set pulse
        do_reset();
        enable = 1'b1;
        cyc(4);
        chk("t2_set", 1, 0, 1, 0, 2'd0);
        cyc(2);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        chk("t2_clr", 0, 1, 0, 0, 2'd0);
        cyc(1);
        chk("t2_next_set", 1, 0, 1, 0, 2'd0);

        // 3: ack coincident with the second tick replaces the request
        do_reset();
        enable = 1'b1;
        cyc(4);
        chk("t3_set", 1, 0, 1, 0, 2'd0);
        cyc(3);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        chk("t3_tick_and_ack", 1, 0, 1, 0, 2'd0);
        cyc(1);
        chk("t3_after", 0, 0, 1, 0, 2'd0);

        // 4: ack held high through IDLE, then through a tick
        do_reset();
        ack  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            seen = seen | clr_pulse | pending;
        end
        chk_bit("t4_idle_ack_ignored", seen, 1'b0);
        enable = 1'b1;
        cyc(4);
        chk("t4_set", 1, 0, 1, 0, 2'd0);
        cyc(1);
        chk("t4_clr", 0, 1, 0, 0, 2'd0);
        cyc(1);
        chk("t4_clr_once_a", 0, 0, 0, 0, 2'd0);
        cyc(1);
        chk("t4_clr_once_b", 0, 0, 0, 0, 2'd0);
        ack = 1'b0;

        // 5: clr_ovr coincident with an overrun, then alone
        do_reset();
        enable = 1'b1;
        cyc(8);
        chk("t5_ovr1", 0, 0, 1, 1, 2'd1);
        cyc(4);
        chk("t5_ovr2", 0, 0, 1, 1, 2'd2);
        cyc(3);
        clr_ovr = 1'b1;
        cyc(1);
        chk("t5_clr_with_ovr", 0, 0, 1, 1, 2'd1);
        cyc(1);
        clr_ovr = 1'b0;
        chk("t5_clr_alone", 0, 0, 1, 0, 2'd0);

        // 6: asynchronous reset mid-cycle while pending with an overrun
        do_reset();
        enable = 1'b1;
        cyc(8);
        chk("t6_pre_reset", 0, 0, 1, 1, 2'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_reset", 0, 0, 0, 0, 2'd0);
        cyc(1);
        chk("t6_held_in_reset", 0, 0, 0, 0, 2'd0);
        #2;
        reset_n = 1'b1;
        cyc(3);
        chk("t6_no_early_set", 0, 0, 0, 0, 2'd0);
        cyc(1);
        chk("t6_first_set_after_reset", 1, 0, 1, 0, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
